// File: rtl/efuse_pkg.sv
// Shared eFuse definitions: macro geometry, program FSM states and the
// segment bit ordering used by both the program and read controllers.
package efuse_pkg;

   localparam int EFUSE_BITS = 256;
   localparam int EFUSE_AW   = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SCAN,
      AEN_HI,
      AEN_LO,
      HOLD,
      DONE
   } efuse_pgm_state_e;

   // Burn index -> data bit, so fuse byte 0 reads back as data[nr-1 -: 8].
   function automatic int unsigned efuse_data_idx(input int unsigned nr, input int unsigned idx);
      return nr - 8 - 8 * (idx / 8) + (idx % 8);
   endfunction

endpackage

// File: rtl/efuse_tmr.sv
// Shared dwell timer: loads max(val,1) and counts down; expire_o marks the
// last cycle of the loaded interval.
module efuse_tmr (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] val_i,
   output logic       expire_o
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = (val_i == 8'd0) ? 8'd1 : val_i;
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = (cnt_q == 8'd1);

endmodule

// File: rtl/efuse_pgm.sv
// eFuse program controller: burns the 1-bits of one NR-bit segment, one AEN
// pulse per bit, with setup/hold framing and a non-truncating abort.
module efuse_pgm
   import efuse_pkg::*;
#(
   parameter  int NR   = 64,
   localparam int RSEL = EFUSE_BITS / NR,
   localparam int SELW = (RSEL > 1) ? $clog2(RSEL) : 1,
   localparam int IDXW = $clog2(NR),
   localparam int CNTW = $clog2(NR) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [7:0]          rg_efuse_tpgm,
   input  logic [3:0]          rg_efuse_tsu,
   input  logic [SELW-1:0]     pgm_sel,
   input  logic [NR-1:0]       pgm_data,
   input  logic                pgm_start,
   input  logic                pgm_abort,
   output logic                pgm_done,
   output logic                busy_pgm,
   output logic [CNTW-1:0]     pgm_bit_cnt,
   output logic                efuse_pgmen_o,
   output logic                efuse_rden_o,
   output logic                efuse_aen_o,
   output logic [EFUSE_AW-1:0] efuse_addr_o
);

   efuse_pgm_state_e    state_q, state_d;
   logic [IDXW-1:0]     idx_q, idx_d;
   logic [NR-1:0]       data_q, data_d;
   logic [SELW-1:0]     sel_q, sel_d;
   logic [CNTW-1:0]     cnt_q, cnt_d;
   logic                abort_q, abort_d;
   logic                busy_q, aen_q, done_q;
   logic [EFUSE_AW-1:0] addr_q, addr_d;

   logic                tmr_load;
   logic [7:0]          tmr_val;
   logic                tmr_expire;

   logic [IDXW-1:0]     data_idx;
   logic                data_bit;
   logic                last_idx;
   logic                abort_seen;

   assign data_idx   = IDXW'(efuse_data_idx(32'(NR), 32'(idx_q)));
   assign data_bit   = data_q[data_idx];
   assign last_idx   = (idx_q == IDXW'(NR - 1));
   assign abort_seen = abort_q | pgm_abort;

   efuse_tmr u_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (tmr_load),
      .val_i    (tmr_val),
      .expire_o (tmr_expire)
   );

   // Every state change reloads the timer; only AEN_HI uses tpgm.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      data_d   = data_q;
      sel_d    = sel_q;
      cnt_d    = cnt_q;
      abort_d  = abort_q;
      tmr_load = 1'b0;
      tmr_val  = {4'd0, rg_efuse_tsu};

      if (busy_q && pgm_abort) begin
         abort_d = 1'b1;
      end

      case (state_q)
         IDLE, DONE: begin
            if (pgm_start) begin
               state_d  = SETUP;
               data_d   = pgm_data;
               sel_d    = pgm_sel;
               cnt_d    = '0;
               idx_d    = '0;
               abort_d  = 1'b0;
               tmr_load = 1'b1;
            end
         end
         SETUP: begin
            if (tmr_expire) begin
               state_d  = abort_seen ? HOLD : SCAN;
               tmr_load = 1'b1;
            end
         end
         SCAN: begin
            if (abort_seen) begin
               state_d  = HOLD;
               tmr_load = 1'b1;
            end else if (data_bit) begin
               state_d  = AEN_HI;
               tmr_load = 1'b1;
               tmr_val  = rg_efuse_tpgm;
               cnt_d    = cnt_q + 1'b1;
            end else if (last_idx) begin
               state_d  = HOLD;
               tmr_load = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         AEN_HI: begin
            if (tmr_expire) begin
               state_d  = AEN_LO;
               tmr_load = 1'b1;
            end
         end
         AEN_LO: begin
            if (tmr_expire) begin
               if (last_idx || abort_seen) begin
                  state_d  = HOLD;
                  tmr_load = 1'b1;
               end else begin
                  state_d = SCAN;
                  idx_d   = idx_q + 1'b1;
               end
            end
         end
         HOLD: begin
            if (tmr_expire) begin
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Segment base is a multiple of 8, so this equals {byte_addr[4:0], bit[2:0]}.
      addr_d = EFUSE_AW'(32'(sel_d) * 32'(NR) + 32'(idx_d));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         data_q  <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         abort_q <= 1'b0;
         busy_q  <= 1'b0;
         aen_q   <= 1'b0;
         done_q  <= 1'b0;
         addr_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         abort_q <= abort_d;
         busy_q  <= (state_d != IDLE) && (state_d != DONE);
         aen_q   <= (state_d == AEN_HI);
         done_q  <= (state_d == DONE);
         addr_q  <= addr_d;
      end
   end

   assign busy_pgm      = busy_q;
   assign efuse_pgmen_o = busy_q;
   assign efuse_aen_o   = aen_q;
   assign pgm_done      = done_q;
   assign pgm_bit_cnt   = cnt_q;
   assign efuse_addr_o  = addr_q;
   assign efuse_rden_o  = 1'b0;

endmodule

// File: doc/efuse_pgm.md
Name: efuse_pgm

Overview:
- eFuse program controller. It burns one NR-bit segment of the 256-bit eFuse macro, one bit at a time, and burns only bits whose data value is 1.
- Sits beside the eFuse read controller, behind the same digital register interface, and drives the same macro pins (pgmen/rden/aen/addr).
- The segment byte/bit layout matches the read path, so a read-back of segment S returns the programmed pgm_data unchanged.

Parameters:
- NR, 64, segment width in bits; multiple of 8; 256 % NR == 0.
- RSEL, 256/NR, number of segments.
- EFUSE_BITS, 256, total fuse bits; the eFuse bit address is 8 bits wide.

Ports:
- clk  in  1  controller clock (6.5 MHz domain).
- rst_n  in  1  asynchronous active-low reset.
- rg_efuse_tpgm  in  8  AEN high (burn) width in clk cycles; 0 is treated as 1.
- rg_efuse_tsu  in  4  setup/gap/hold width in clk cycles; 0 is treated as 1.
- pgm_sel  in  $clog2(RSEL)  target segment index.
- pgm_data  in  NR  data to burn; sampled on pgm_start.
- pgm_start  in  1  single-cycle start request.
- pgm_abort  in  1  level request to stop early.
- pgm_done  out  1  sticky completion flag.
- busy_pgm  out  1  high while the operation is active.
- pgm_bit_cnt  out  $clog2(NR)+1  number of AEN pulses issued in the current or last operation.
- efuse_pgmen_o  out  1  program enable.
- efuse_rden_o  out  1  read enable; tied to 0.
- efuse_aen_o  out  1  burn strobe.
- efuse_addr_o  out  8  bit address = {byte_addr[4:0], bit_in_byte[2:0]}.

Behaviour:
- Reset values:
  - All outputs are 0.
  - The FSM is in IDLE.
  - The latched data and the index are 0.
- pgm_start in IDLE:
  - Latch pgm_data and pgm_sel.
  - Clear pgm_done and pgm_bit_cnt.
  - Set idx=0.
  - Next cycle: busy_pgm=1, efuse_pgmen_o=1, state SETUP.
- pgm_start is ignored in any state other than IDLE or DONE. DONE behaves like IDLE for start.
- Index mapping, with base = NR*sel:
  - idx runs 0..NR-1.
  - byte k = idx/8, bit j = idx%8.
  - byte_addr = base/8 + k.
  - Data bit used = data[NR-8-8k+j]. This puts the first byte read back in read_data[NR-1:NR-8].
- States:
  - SETUP: wait tsu cycles, then go to SCAN.
  - SCAN: inspect the data bit at idx, one idx per cycle.
    - Bit = 1: go to AEN_HI.
    - Bit = 0 and idx < NR-1: idx++, stay in SCAN.
    - Bit = 0 and idx == NR-1: go to HOLD.
  - AEN_HI: efuse_aen_o=1 for exactly tpgm cycles, then go to AEN_LO. pgm_bit_cnt++ on entry.
  - AEN_LO: efuse_aen_o=0 for tsu cycles.
    - idx == NR-1 or abort pending: go to HOLD.
    - Otherwise: idx++, go to SCAN.
  - HOLD: efuse_pgmen_o stays 1 for tsu cycles, then go to DONE.
  - DONE: efuse_pgmen_o=0, busy_pgm=0, pgm_done=1 (all from the same edge). Remain until the next pgm_start.
- Address stability:
  - efuse_addr_o changes only while efuse_aen_o=0.
  - efuse_addr_o is stable for at least 1 cycle before the AEN rise and after the AEN fall.
- efuse_aen_o is only ever high while efuse_pgmen_o=1. AEN_HI is never entered from SETUP or HOLD without passing through SCAN.
- pgm_abort:
  - Sampled every cycle while busy_pgm=1; once seen, it is latched as pending.
  - In SETUP or SCAN: go to HOLD on the next transition.
  - In AEN_HI: the pulse completes its full tpgm width, then AEN_LO, then HOLD. A burn pulse is never truncated.
  - An aborted operation still ends in DONE with pgm_done=1; pgm_bit_cnt reports the pulses actually issued.
- Timer:
  - One shared down-counter, loaded on each state entry with max(value,1).
  - tpgm and tsu are sampled at load, not held constant across the operation.
- Total pulse count is popcount(pgm_data). All-zero data gives zero AEN pulses but still runs SETUP and HOLD.
- Asynchronous reset mid-operation drops pgmen and aen immediately. No recovery is attempted; the state of the fuse bit being burned is undefined.

Decomposition:
- efuse_pkg holds:
  - EFUSE_BITS and EFUSE_AW=8.
  - The state enum efuse_pgm_state_e (IDLE, SETUP, SCAN, AEN_HI, AEN_LO, HOLD, DONE).
  - A function that computes the byte-mapped data index.
  - The read controller imports efuse_pkg as well.
- One sub-module: efuse_tmr. It is an 8-bit load/down-counter with an expire flag and implements the min-1 clamp.

Test Plan:
- NR=64, sel=1, data=64'h8000_0000_0000_0001, tpgm=10, tsu=2 → two AEN pulses of 10 cycles each at addr 0x47 and 0x78. pgm_bit_cnt=2, then pgm_done=1.
- data=0 → no AEN pulse. pgmen is high for 2+64+2 cycles, then done=1 and bit_cnt=0.
- data=all-ones, sel=3, tpgm=0, tsu=0 → 64 one-cycle pulses at addr 0xC0..0xFF. The address never changes while AEN=1.
- pgm_abort raised on cycle 3 of the second pulse (tpgm=10) → the second pulse lasts the full 10 cycles, there is no third pulse, bit_cnt=2, done=1.
- pgm_start reissued mid-operation with different data → ignored; the original pulse sequence and count are unchanged.
- rst_n asserted during AEN_HI → aen, pgmen, busy and done are all 0 asynchronously. A subsequent start runs a normal operation.
